// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace-tree multiplier: product-width helper,
// default row typedefs and the reduction-depth arithmetic used to size the
// tree at elaboration time.
package wallace_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int PROD_W        = 2 * DEFAULT_WIDTH;

    // Sum and carry rows at the default operand width.
    typedef logic [PROD_W-1:0] sum_row_t;
    typedef logic [PROD_W-1:0] carry_row_t;

    // Product width for a given operand width.
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Rows left after a number of 3:2 layers: every group of three rows
    // becomes two, leftover rows pass through unchanged.
    function automatic int rows_after(input int rows, input int layers);
        int r;
        r = rows;
        for (int l = 0; l < layers; l++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    // Number of Wallace layers needed to reduce `rows` rows down to two.
    function automatic int wallace_layers(input int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/wallace_csa.sv
// Full-adder bit cell (3:2 counter) used throughout the Wallace layers.
module wallace_csa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/wallace_tree_mult.sv
// Two-stage pipelined signed multiplier. Baugh-Wooley partial products are
// reduced by a Wallace tree of wallace_csa cells to a sum/carry pair, which
// is registered and then added by a carry-propagate adder in stage 2.
// Optional macro MULT_UNSIGNED_CTRL_EN adds input tc (1 = signed, 0 = unsigned).
module wallace_tree_mult
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef MULT_UNSIGNED_CTRL_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int PW = prod_width(WIDTH);
    // WIDTH partial-product rows plus one row holding the correction constants.
    localparam int NR = WIDTH + 1;
    localparam int NL = wallace_layers(NR);

    logic signed_mode;

`ifdef MULT_UNSIGNED_CTRL_EN
    // tc is consumed by the stage-1 partial-product logic, so it is sampled
    // on the same edge as x/y and travels with them into the sum/carry rows.
    assign signed_mode = tc;
`else
    assign signed_mode = 1'b1;
`endif

    logic [PW-1:0] pp   [0:NR-1];
    logic [PW-1:0] tree [0:NL][0:NR-1];

    // Baugh-Wooley partial products: MSB-row/MSB-column terms inverted in
    // signed mode (the corner term is not), plus constants at WIDTH and PW-1.
    always_comb begin
        // NOTE: every row is cleared first so no bit is left unassigned on any path, which would infer a latch.
        for (int r = 0; r < NR; r++) begin
            pp[r] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (x[j] & y[i]) ^
                             (signed_mode & ((i == WIDTH-1) ^ (j == WIDTH-1)));
            end
        end
        pp[NR-1][WIDTH] = signed_mode;
        pp[NR-1][PW-1]  = signed_mode;
    end

    for (genvar r = 0; r < NR; r++) begin : g_layer0
        assign tree[0][r] = pp[r];
    end

    for (genvar l = 0; l < NL; l++) begin : g_layer
        localparam int RIN  = rows_after(NR, l);
        localparam int ROUT = rows_after(NR, l + 1);
        localparam int NG   = RIN / 3;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [PW-1:0] s;
            logic [PW-2:0] co;
            for (genvar bi = 0; bi < PW - 1; bi++) begin : g_bit
                wallace_csa u_csa (
                    .a  (tree[l][3*g][bi]),
                    .b  (tree[l][3*g+1][bi]),
                    .c  (tree[l][3*g+2][bi]),
                    .s  (s[bi]),
                    .co (co[bi])
                );
            end
            // Top column: its carry would land beyond the product width.
            assign s[PW-1] = tree[l][3*g][PW-1] ^ tree[l][3*g+1][PW-1] ^
                             tree[l][3*g+2][PW-1];
            assign tree[l+1][2*g]   = s;
            assign tree[l+1][2*g+1] = {co, 1'b0};
        end

        for (genvar k = 0; k < RIN - 3*NG; k++) begin : g_pass
            assign tree[l+1][2*NG+k] = tree[l][3*NG+k];
        end

        for (genvar k = ROUT; k < NR; k++) begin : g_pad
            assign tree[l+1][k] = '0;
        end
    end

    logic          s1_valid;
    logic [PW-1:0] s1_sum;
    logic [PW-1:0] s1_carry;

    // Stage 1: capture the reduced sum/carry rows when the inputs are valid.
    always_ff @(posedge clk) begin
        // NOTE: every pipeline register is reset so a reset drops in-flight results and clears the output.
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= tree[NL][0];
                s1_carry <= tree[NL][1];
            end
        end
    end

    // Stage 2: carry-propagate add; prod holds while no valid data arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            prod      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                prod <= s1_sum + s1_carry;
            end
        end
    end

endmodule

// File: tb/tb_wallace_tree_mult.sv
// Scoreboard bench for wallace_tree_mult at WIDTH=16: the driver pushes the
// expected product with its issue cycle, the monitor pops on out_valid and
// checks value and latency, and checks that prod holds while out_valid=0.
module tb_wallace_tree_mult;
    import wallace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        tc_drv;
    logic        out_valid;
    logic [31:0] prod;

    typedef struct {
        sum_row_t exp;
        int       issue_cycle;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_vec  = 0;
    int        n_fail = 0;
    int        cycle  = 0;
    sum_row_t  hold_exp = '0;

    wallace_tree_mult #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
`ifdef MULT_UNSIGNED_CTRL_EN
        .tc        (tc_drv),
`endif
        .out_valid (out_valid),
        .prod      (prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check("prod", prod, e.exp);
                check("latency", cycle - e.issue_cycle, 32'd2);
                hold_exp = e.exp;
            end
        end else begin
            check("prod_hold", prod, hold_exp);
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic t, input logic [31:0] e);
        sb_entry_t ent;
        @(negedge clk);
        x        = a;
        y        = b;
        tc_drv   = t;
        in_valid = 1'b1;
        ent.exp         = e;
        ent.issue_cycle = cycle;
        sb.push_back(ent);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Hand-computed directed vectors {x, y, expected product}.
    localparam int NDIR = 18;
    logic [15:0] dir_x [NDIR] = '{16'hFFFC, 16'hFFCD, 16'hFFFB, 16'hFFFF,
                                 16'd41, 16'd0, 16'd1011, 16'd4011, 16'd7,
                                 16'h8000, 16'h8000, 16'h7FFF, 16'h8000,
                                 16'hFFFF, 16'hFFF9, 16'h0000, 16'h7FFF, 16'h8000};
    logic [15:0] dir_y [NDIR] = '{16'd12, 16'd2, 16'd5, 16'd1,
                                 16'd12, 16'd142, 16'd15, 16'd142, 16'd8,
                                 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001,
                                 16'hFFFF, 16'hFFF7, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic [31:0] dir_p [NDIR] = '{32'hFFFFFFD0, 32'hFFFFFF9A, 32'hFFFFFFE7, 32'hFFFFFFFF,
                                 32'd492, 32'd0, 32'd15165, 32'h0008B0DA, 32'd56,
                                 32'h40000000, 32'hC0008000, 32'h3FFF0001, 32'hFFFF8000,
                                 32'h00000001, 32'h0000003F, 32'h00000000, 32'hFFFF8001,
                                 32'h00008000};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        tc_drv   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_prod", prod, 32'h0);
        rst_n = 1'b1;

        // First nine vectors streamed back-to-back, then a gap.
        for (int i = 0; i < 9; i++) issue(dir_x[i], dir_y[i], 1'b1, dir_p[i]);
        idle(5);

        // Remaining vectors with gaps between them.
        for (int i = 9; i < NDIR; i++) begin
            issue(dir_x[i], dir_y[i], 1'b1, dir_p[i]);
            idle(2);
        end
        idle(3);

`ifdef MULT_UNSIGNED_CTRL_EN
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        issue(16'h8000, 16'h8000, 1'b0, 32'h40000000);
        issue(16'hFFFC, 16'd12,   1'b0, 32'h000BFFD0);
        idle(4);
`endif

        // Reset while two results are in flight: neither may appear.
        @(negedge clk);
        x = 16'd100; y = 16'd3; in_valid = 1'b1;
        @(negedge clk);
        x = 16'd200; y = 16'd5; in_valid = 1'b1;
        rst_n    = 1'b0;
        hold_exp = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("midreset_out_valid", {31'b0, out_valid}, 32'h0);
        check("midreset_prod", prod, 32'h0);
        idle(5);

        // Streamed random pairs against a behavioural reference.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [31:0] e;
            a = 16'($urandom);
            b = 16'($urandom);
            e = 32'($signed(a) * $signed(b));
            issue(a, b, 1'b1, e);
        end
        idle(1);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
